// File: rtl/mixcol_seq.sv
// mixcol_seq: control sequencer for a byte-serial 4-byte column register that
// feeds MixColumns. One block takes 16 bytes in and puts 16 bytes out over
// 20 cycles. con_sel reloads each column with its MixColumns result, unless
// the block was started as the last round.
// Optional feature macro: MIXSEQ_OVERLAP_EN. When it is defined, a new block
// may start while the previous block drains its last bytes.
module mixcol_seq #(
  parameter int NBYTES = 16,
  parameter int CNT_W  = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       last_round,
  output logic       busy,
  output logic       in_req,
  output logic [3:0] in_idx,
  output logic       con_sel,
  output logic       dout_valid,
  output logic [3:0] out_idx,
  output logic       done
);

  localparam logic [CNT_W-1:0] C_FILL_END = CNT_W'(3);
  localparam logic [CNT_W-1:0] C_RUN_END  = CNT_W'(NBYTES - 1);
  localparam logic [CNT_W-1:0] C_LAST     = CNT_W'(NBYTES + 3);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DRAIN} state_t;

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_cyc, w_cyc_next;
  logic             r_bypass, w_bypass_next;
  logic             w_accept;
  logic             w_main_out;

  // State, block cycle counter and the latched bypass flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cyc    <= '0;
      r_bypass <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cyc    <= w_cyc_next;
      r_bypass <= w_bypass_next;
    end
  end

  // Next-state logic; an accepted start always restarts the block at cycle 0
  always_comb begin
    w_state_next  = r_state;
    w_cyc_next    = r_cyc;
    w_bypass_next = r_bypass;
    w_accept      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_accept = start;
      end
      S_FILL: begin
        w_cyc_next = r_cyc + CNT_W'(1);
        if (r_cyc == C_FILL_END) w_state_next = S_RUN;
      end
      S_RUN: begin
        w_cyc_next = r_cyc + CNT_W'(1);
        if (r_cyc == C_RUN_END) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
`ifdef MIXSEQ_OVERLAP_EN
        w_accept = start;
`endif
        if (r_cyc == C_LAST) begin
          w_state_next = S_IDLE;
          w_cyc_next   = '0;
        end else begin
          w_cyc_next = r_cyc + CNT_W'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cyc_next   = '0;
      end
    endcase
    if (w_accept) begin
      w_state_next  = S_FILL;
      w_cyc_next    = '0;
      w_bypass_next = last_round;
    end
  end

  assign w_main_out = (r_state == S_RUN) || (r_state == S_DRAIN);

`ifdef MIXSEQ_OVERLAP_EN
  localparam logic [3:0] C_LAST_COL = 4'(NBYTES - 4);

  // Drain counter: finishes the old block's last bytes after a restart
  logic       r_dact;
  logic [1:0] r_dcnt;

  // The handoff happens only when old output bytes remain after this cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dact <= 1'b0;
      r_dcnt <= 2'd0;
    end else if (w_accept && (r_state == S_DRAIN) && (r_cyc != C_LAST)) begin
      r_dact <= 1'b1;
      r_dcnt <= 2'(r_cyc - C_RUN_END);
    end else if (r_dact) begin
      r_dact <= (r_dcnt != 2'd3);
      r_dcnt <= (r_dcnt == 2'd3) ? 2'd0 : r_dcnt + 2'd1;
    end
  end

  // Outputs: input side follows the new block, output side merges both
  always_comb begin
    busy       = (r_state == S_FILL) || (r_state == S_RUN);
    in_req     = busy;
    in_idx     = in_req ? r_cyc[3:0] : 4'd0;
    con_sel    = w_main_out && !r_bypass && (r_cyc[1:0] == 2'd0);
    dout_valid = w_main_out || r_dact;
    out_idx    = 4'd0;
    if (r_dact)          out_idx = {C_LAST_COL[3:2], r_dcnt};
    else if (w_main_out) out_idx = 4'(r_cyc - CNT_W'(4));
    done       = (r_dact && (r_dcnt == 2'd3)) ||
                 ((r_state == S_DRAIN) && (r_cyc == C_LAST));
  end
`else
  // Outputs decoded from state and block cycle; loads land on cycles 4,8,12,16
  always_comb begin
    busy       = (r_state != S_IDLE);
    in_req     = (r_state == S_FILL) || (r_state == S_RUN);
    in_idx     = in_req ? r_cyc[3:0] : 4'd0;
    con_sel    = w_main_out && !r_bypass && (r_cyc[1:0] == 2'd0);
    dout_valid = w_main_out;
    out_idx    = w_main_out ? 4'(r_cyc - CNT_W'(4)) : 4'd0;
    done       = (r_state == S_DRAIN) && (r_cyc == C_LAST);
  end
`endif

endmodule
